// File: rtl/dma_ext_arb_pkg.sv
// rtl/dma_ext_arb_pkg.sv - width helpers shared by the external DMA request arbiter
package dma_ext_arb_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int max_cnt);
        return $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/dma_ext_req_arbiter_if.sv
// rtl/dma_ext_req_arbiter_if.sv - downstream descriptor/completion port towards the cluster frontend
interface dma_ext_req_arbiter_if #(
    parameter type descr_t = logic
) ();
    logic   dma_req_valid_o;
    logic   dma_req_ready_i;
    descr_t dma_req_o;
    logic   dma_rsp_valid_i;

    modport master (
        output dma_req_valid_o,
        output dma_req_o,
        input  dma_req_ready_i,
        input  dma_rsp_valid_i
    );

    modport slave (
        input  dma_req_valid_o,
        input  dma_req_o,
        output dma_req_ready_i,
        output dma_rsp_valid_i
    );
endinterface

// File: rtl/dma_ext_arb_id_fifo.sv
// rtl/dma_ext_arb_id_fifo.sv - in-order channel ID FIFO; full ignores a same-cycle pop, no fall-through
module dma_ext_arb_id_fifo
    import dma_ext_arb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = idx_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign data_o  = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dma_ext_req_arbiter.sv
// rtl/dma_ext_req_arbiter.sv - round-robin mux of external DMA requesters with in-order completion routing
// Optional DMA_EXT_ARB_CUT_EN inserts a spill register on the downstream request port.
module dma_ext_req_arbiter
    import dma_ext_arb_pkg::*;
#(
    parameter int  NB_CHANNELS        = 4,
    parameter int  MAX_OUTSTANDING    = 8,
    parameter int  MAX_CH_OUTSND      = 4,
    parameter type dma_transf_descr_t = logic
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NB_CHANNELS-1:0]   req_valid_i,
    output logic [NB_CHANNELS-1:0]   req_ready_o,
    input  dma_transf_descr_t        req_i [NB_CHANNELS],
    output logic [NB_CHANNELS-1:0]   rsp_valid_o,
    dma_ext_req_arbiter_if.master    dma_port,
    output logic [NB_CHANNELS-1:0]   no_req_pending_o,
    output logic                     busy_o,
    output logic                     err_o
);
    localparam int IW = idx_width(NB_CHANNELS);
    localparam int CW = cnt_width(MAX_CH_OUTSND);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CH_OUTSND);

    typedef logic [IW-1:0] ch_idx_t;
    localparam ch_idx_t LAST_CH = ch_idx_t'(NB_CHANNELS - 1);

    logic [CW-1:0]    r_cnt [NB_CHANNELS];
    ch_idx_t          r_rr_ptr;
    ch_idx_t          w_granted;
    ch_idx_t          w_grant_hi;
    ch_idx_t          w_grant_lo;
    ch_idx_t          w_head;
    logic [NB_CHANNELS-1:0] w_eligible;
    logic [NB_CHANNELS-1:0] r_rsp_valid;
    logic             w_hi_found;
    logic             w_arb_valid;
    logic             w_arb_ready;
    logic             w_accept;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             r_err;

    always_comb begin
        for (int i = 0; i < NB_CHANNELS; i++) begin
            w_eligible[i]       = req_valid_i[i] & (r_cnt[i] < CNT_MAX) & ~w_fifo_full;
            no_req_pending_o[i] = (r_cnt[i] == '0);
        end
    end

    // Lowest eligible index at/after the pointer wins; otherwise wrap to the lowest eligible overall.
    always_comb begin
        w_grant_hi = '0;
        w_grant_lo = '0;
        w_hi_found = 1'b0;
        for (int i = NB_CHANNELS - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_grant_lo = ch_idx_t'(i);
                if (i >= int'(r_rr_ptr)) begin
                    w_grant_hi = ch_idx_t'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
    end

    assign w_granted   = w_hi_found ? w_grant_hi : w_grant_lo;
    assign w_arb_valid = |w_eligible;
    assign w_accept    = w_arb_valid & w_arb_ready;

    always_comb begin
        req_ready_o = '0;
        if (w_arb_valid) begin
            req_ready_o[w_granted] = w_arb_ready;
        end
    end

`ifdef DMA_EXT_ARB_CUT_EN
    dma_transf_descr_t r_a_data;
    dma_transf_descr_t r_b_data;
    logic              r_a_valid;
    logic              r_b_valid;
    logic              w_a_load;

    // Slot B absorbs one descriptor while slot A stalls, so upstream ready never depends on the frontend.
    assign w_arb_ready = ~r_b_valid;
    assign w_a_load    = ~r_a_valid | dma_port.dma_req_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a_valid <= 1'b0;
            r_b_valid <= 1'b0;
            r_a_data  <= '0;
            r_b_data  <= '0;
        end else if (w_a_load) begin
            if (r_b_valid) begin
                r_a_valid <= 1'b1;
                r_a_data  <= r_b_data;
                r_b_valid <= 1'b0;
            end else begin
                r_a_valid <= w_accept;
                r_a_data  <= req_i[w_granted];
            end
        end else if (w_accept) begin
            r_b_valid <= 1'b1;
            r_b_data  <= req_i[w_granted];
        end
    end

    assign dma_port.dma_req_valid_o = r_a_valid;
    assign dma_port.dma_req_o       = r_a_data;
`else
    assign w_arb_ready              = dma_port.dma_req_ready_i;
    assign dma_port.dma_req_valid_o = w_arb_valid;
    assign dma_port.dma_req_o       = req_i[w_granted];
`endif

    assign w_pop = dma_port.dma_rsp_valid_i & ~w_fifo_empty;

    dma_ext_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_accept),
        .data_i  (w_granted),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr    <= '0;
            r_rsp_valid <= '0;
            r_err       <= 1'b0;
            for (int i = 0; i < NB_CHANNELS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_rr_ptr <= (w_granted == LAST_CH) ? '0 : w_granted + 1'b1;
            end
            r_rsp_valid <= '0;
            if (w_pop) begin
                r_rsp_valid[w_head] <= 1'b1;
            end
            if (dma_port.dma_rsp_valid_i & w_fifo_empty) begin
                r_err <= 1'b1;
            end
            for (int i = 0; i < NB_CHANNELS; i++) begin
                case ({w_accept && (w_granted == ch_idx_t'(i)), w_pop && (w_head == ch_idx_t'(i))})
                    2'b10:   r_cnt[i] <= r_cnt[i] + 1'b1;
                    2'b01:   r_cnt[i] <= r_cnt[i] - 1'b1;
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign busy_o      = ~w_fifo_empty;
    assign err_o       = r_err;

endmodule

// File: tb/tb_dma_ext_req_arbiter.sv
// tb/tb_dma_ext_req_arbiter.sv - randomized scoreboard bench for dma_ext_req_arbiter
module tb_dma_ext_req_arbiter;
    localparam int NB_CH   = 4;
    localparam int MAX_OUT = 8;
    localparam int MAX_CH  = 4;
    typedef logic [15:0] descr_t;

    typedef struct { int ch; descr_t d; int cyc; } acc_exp_t;
    typedef struct { int ch; int cyc; } rsp_exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NB_CH-1:0] req_valid = '0;
    logic [NB_CH-1:0] req_ready;
    logic [NB_CH-1:0] rsp_valid;
    logic [NB_CH-1:0] no_req_pending;
    descr_t           req [NB_CH];
    logic             busy;
    logic             err;

    dma_ext_req_arbiter_if #(.descr_t(descr_t)) dma_if ();

    dma_ext_req_arbiter #(
        .NB_CHANNELS        (NB_CH),
        .MAX_OUTSTANDING    (MAX_OUT),
        .MAX_CH_OUTSND      (MAX_CH),
        .dma_transf_descr_t (descr_t)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_i            (req),
        .rsp_valid_o      (rsp_valid),
        .dma_port         (dma_if),
        .no_req_pending_o (no_req_pending),
        .busy_o           (busy),
        .err_o            (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    acc_exp_t acc_q[$];
    rsp_exp_t rsp_q[$];

    // Reference state: per-channel in-flight counts and the global in-flight order.
    int     m_cnt [NB_CH];
    int     m_fifo[$];
    int     m_rr;
    bit     m_err;
    bit     drv_v [NB_CH];
    descr_t drv_d [NB_CH];
    int     last_grant;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB_CH; i++) begin
            m_cnt[i] = 0;
            drv_v[i] = 1'b0;
            drv_d[i] = '0;
        end
        m_fifo.delete();
        m_rr = 0;
        m_err = 1'b0;
        last_grant = -1;
        acc_q.delete();
        rsp_q.delete();
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = '0;
        for (int i = 0; i < NB_CH; i++) req[i] = '0;
        dma_if.dma_req_ready_i = 1'b1;
        dma_if.dma_rsp_valid_i = 1'b0;
        model_reset();
        #2;
        check("reset_values",
              {req_ready, rsp_valid, dma_if.dma_req_valid_o, busy, err, no_req_pending},
              {8'h00, 3'b000, 4'hf});
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic do_cycle(input logic [NB_CH-1:0] mask, input int p_valid, input int p_ready,
                            input int p_rsp, input bit force_rsp);
        bit               rsp_in;
        bit               rdy;
        bit               any;
        bit               accept;
        int               g;
        int               c;
        int               h;
        logic [NB_CH-1:0] exp_ready;
        logic [NB_CH-1:0] exp_nrp;
        @(posedge clk);
        #1;
        for (int i = 0; i < NB_CH; i++) begin
            if (last_grant == i) drv_v[i] = 1'b0;
            if (!drv_v[i] && mask[i] && ($urandom_range(99) < p_valid)) begin
                drv_v[i] = 1'b1;
                drv_d[i] = descr_t'($urandom);
            end
            req_valid[i] = drv_v[i];
            req[i] = drv_v[i] ? drv_d[i] : descr_t'($urandom);
        end
        rdy = ($urandom_range(99) < p_ready);
        rsp_in = force_rsp || ((m_fifo.size() > 0) && ($urandom_range(99) < p_rsp));
        dma_if.dma_req_ready_i = rdy;
        dma_if.dma_rsp_valid_i = rsp_in;
        #2;
        g = -1;
        for (int k = 0; k < NB_CH; k++) begin
            c = (m_rr + k) % NB_CH;
            if (g < 0 && drv_v[c] && m_cnt[c] < MAX_CH && m_fifo.size() < MAX_OUT) g = c;
        end
        any = (g >= 0);
        accept = any && rdy;
        exp_ready = '0;
        if (any) exp_ready[g] = rdy;
        for (int i = 0; i < NB_CH; i++) exp_nrp[i] = (m_cnt[i] == 0);
        check("levels", {dma_if.dma_req_valid_o, req_ready, busy, no_req_pending, err},
              {any, exp_ready, (m_fifo.size() > 0), exp_nrp, m_err});
        if (accept) acc_q.push_back('{ch: g, d: drv_d[g], cyc: cyc});
        if (rsp_in) begin
            if (m_fifo.size() > 0) begin
                h = m_fifo.pop_front();
                m_cnt[h]--;
                rsp_q.push_back('{ch: h, cyc: cyc + 1});
            end else begin
                m_err = 1'b1;
            end
        end
        if (accept) begin
            m_fifo.push_back(g);
            m_cnt[g]++;
            m_rr = (g + 1) % NB_CH;
        end
        last_grant = accept ? g : -1;
    endtask

    always @(negedge clk) begin : monitor
        acc_exp_t         ea;
        rsp_exp_t         er;
        logic [NB_CH-1:0] oh;
        if (rst_n) begin
            while (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
                ea = acc_q.pop_front();
                checks++;
                errors++;
                $display("FAIL accept_missing: no handshake, expected channel %0d at cycle %0d", ea.ch, ea.cyc);
            end
            if (dma_if.dma_req_valid_o && dma_if.dma_req_ready_i) begin
                if (acc_q.size() == 0 || acc_q[0].cyc != cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_unexpected: got ready %b, expected no handshake at cycle %0d", req_ready, cyc);
                end else begin
                    ea = acc_q.pop_front();
                    oh = '0;
                    oh[ea.ch] = 1'b1;
                    check("grant_ready", req_ready, oh);
                    check("dma_req_o", dma_if.dma_req_o, ea.d);
                end
            end
            while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
                er = rsp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL rsp_missing: no pulse, expected channel %0d at cycle %0d", er.ch, er.cyc);
            end
            if (|rsp_valid) begin
                if (rsp_q.size() == 0 || rsp_q[0].cyc != cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got %b, expected no pulse at cycle %0d", rsp_valid, cyc);
                end else begin
                    er = rsp_q.pop_front();
                    oh = '0;
                    oh[er.ch] = 1'b1;
                    check("rsp_route", rsp_valid, oh);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        dma_if.dma_req_ready_i = 1'b0;
        dma_if.dma_rsp_valid_i = 1'b0;
        for (int i = 0; i < NB_CH; i++) req[i] = '0;
        model_reset();
        do_reset(3);

        repeat (10) do_cycle(4'b0001, 100, 100, 0, 1'b0);
        repeat (20) do_cycle(4'b0000, 0, 100, 60, 1'b0);
        repeat (40) do_cycle(4'b1111, 100, 100, 50, 1'b0);
        repeat (8)  do_cycle(4'b0100, 100, 100, 0, 1'b0);
        repeat (8)  do_cycle(4'b0100, 100, 100, 30, 1'b0);
        repeat (12) do_cycle(4'b1111, 100, 100, 0, 1'b0);
        repeat (20) do_cycle(4'b1111, 100, 100, 50, 1'b0);
        repeat (300) do_cycle(4'b1111, 40, 70, 40, 1'b0);

        n = 0;
        while (m_fifo.size() > 0 && n < 200) begin
            do_cycle(4'b0000, 0, 100, 100, 1'b0);
            n++;
        end
        repeat (4) do_cycle(4'b0000, 0, 100, 100, 1'b0);
        repeat (2) do_cycle(4'b0000, 0, 100, 0, 1'b0);
        do_cycle(4'b0000, 0, 100, 0, 1'b1);
        repeat (2) do_cycle(4'b0000, 0, 100, 0, 1'b0);
        check("err_sticky", err, 1);

        n = 0;
        while (m_fifo.size() < 5 && n < 20) begin
            do_cycle(4'b0111, 100, 100, 0, 1'b0);
            n++;
        end
        check("busy_before_reset", busy, 1);
        do_reset(2);

        repeat (200) do_cycle(4'b1111, 50, 60, 40, 1'b0);
        n = 0;
        while (m_fifo.size() > 0 && n < 200) begin
            do_cycle(4'b0000, 0, 100, 100, 1'b0);
            n++;
        end
        repeat (4) do_cycle(4'b0000, 0, 100, 100, 1'b0);
        repeat (2) do_cycle(4'b0000, 0, 100, 0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("acc_q_drained", acc_q.size(), 0);
        check("rsp_q_drained", rsp_q.size(), 0);
        check("idle_at_end", {busy, no_req_pending}, {1'b0, 4'hf});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
